// File: rtl/multi_sel_dec.sv
// Receive-side decoder for the multi_sel product stream (d*1, d*3, d*7, d*8).
// Optional checking (compares, word0 fault, abort errors, err_cnt) under MULTI_SEL_DEC_CHK_EN.
module multi_sel_dec (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] din,
    input  logic        input_grant,
    output logic [7:0]  d_out,
    output logic        d_valid,
    output logic        d_err,
    output logic [7:0]  err_cnt
);

    // Each state names the product word expected on din in that cycle.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        S3   = 2'd1,
        S7   = 2'd2,
        S8   = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_cand;
    logic [7:0] w_cand_nxt;
    logic [7:0] r_d_out;
    logic [7:0] w_d_out_nxt;
    logic       r_d_valid;
    logic       w_d_valid_nxt;

`ifdef MULTI_SEL_DEC_CHK_EN
    logic        r_fault;
    logic        w_fault_nxt;
    logic        r_d_err;
    logic        w_d_err_nxt;
    logic [7:0]  r_err_cnt;
    logic [10:0] w_x1;
    logic [10:0] w_x3;
    logic [10:0] w_x7;
    logic [10:0] w_x8;
    logic [10:0] w_expect;
    logic        w_word_bad;

    // Exact 11-bit products; 255*8 = 2040 never wraps.
    assign w_x1 = {3'b000, r_cand};
    assign w_x8 = {r_cand, 3'b000};
    assign w_x3 = w_x1 + {w_x1[9:0], 1'b0};
    assign w_x7 = w_x8 - w_x1;

    always_comb begin
        case (r_state)
            S3:      w_expect = w_x3;
            S7:      w_expect = w_x7;
            default: w_expect = w_x8;
        endcase
    end

    assign w_word_bad = (din != w_expect);
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: any grant restarts at S3, otherwise walk the sequence.
    always_comb begin
        w_state_nxt = r_state;
        if (input_grant) begin
            w_state_nxt = S3;
        end else begin
            case (r_state)
                S3:      w_state_nxt = S7;
                S7:      w_state_nxt = S8;
                S8:      w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Output / datapath next values; everything lands in registers below.
    always_comb begin
        w_cand_nxt    = r_cand;
        w_d_out_nxt   = r_d_out;
        w_d_valid_nxt = 1'b0;
`ifdef MULTI_SEL_DEC_CHK_EN
        w_fault_nxt   = r_fault;
        w_d_err_nxt   = 1'b0;
`endif
        if (input_grant) begin
            w_cand_nxt  = din[7:0];
`ifdef MULTI_SEL_DEC_CHK_EN
            w_fault_nxt = |din[10:8];
            w_d_err_nxt = (r_state != IDLE);
`endif
        end else begin
            case (r_state)
                S3, S7: begin
`ifdef MULTI_SEL_DEC_CHK_EN
                    w_fault_nxt = r_fault | w_word_bad;
`endif
                end
                S8: begin
`ifdef MULTI_SEL_DEC_CHK_EN
                    if (r_fault || w_word_bad) begin
                        w_d_err_nxt = 1'b1;
                    end else begin
                        w_d_valid_nxt = 1'b1;
                        w_d_out_nxt   = r_cand;
                    end
`else
                    w_d_valid_nxt = 1'b1;
                    w_d_out_nxt   = r_cand;
`endif
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cand    <= 8'd0;
            r_d_out   <= 8'd0;
            r_d_valid <= 1'b0;
        end else begin
            r_cand    <= w_cand_nxt;
            r_d_out   <= w_d_out_nxt;
            r_d_valid <= w_d_valid_nxt;
        end
    end

`ifdef MULTI_SEL_DEC_CHK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fault   <= 1'b0;
            r_d_err   <= 1'b0;
            r_err_cnt <= 8'd0;
        end else begin
            r_fault <= w_fault_nxt;
            r_d_err <= w_d_err_nxt;
            if (w_d_err_nxt && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign d_err   = r_d_err;
    assign err_cnt = r_err_cnt;
`else
    assign d_err   = 1'b0;
    assign err_cnt = 8'd0;
`endif

    assign d_out   = r_d_out;
    assign d_valid = r_d_valid;

endmodule

// File: doc/multi_sel_dec.md
# multi_sel_dec

Receive-side decoder for the multiplier-with-select stream produced by `multi_sel`. It consumes the 11-bit product sequence d×1, d×3, d×7, d×8, framed by `input_grant`, and recovers the original 8-bit operand. It checks every product word for consistency and flags corrupt or truncated sequences. It sits downstream of `multi_sel` as its loop-back checker and consumer.

## Interface
Parameters: none (widths fixed by the `multi_sel` protocol: 8-bit operand, 11-bit product).

- `clk` input 1 — single clock; all state updates on rising edge
- `rst` input 1 — synchronous, active-high reset
- `din` input 11 — product word from `multi_sel` `out`
- `input_grant` input 1 — high on the cycle `din` carries d×1 (start of sequence)
- `d_out` output 8 — recovered operand; holds last value until next `d_valid`
- `d_valid` output 1 — one-cycle pulse; `d_out` valid
- `d_err` output 1 — one-cycle pulse; sequence rejected
- `err_cnt` output 8 — count of rejected sequences, saturating

## Operation
- Sequence protocol: four consecutive cycles C0..C3 carry d×1, d×3, d×7, d×8. `input_grant`=1 in C0 only.
- FSM states: IDLE, S3, S7, S8 (the state names the expected next word).
  - IDLE: `input_grant`=1 → capture `cand`=`din[7:0]`, record word0 fault if `din[10:8]`≠0, go S3. Otherwise stay; `din` ignored.
  - S3: compare `din`==`cand`×3 (11-bit, zero-extended), go S7.
  - S7: compare `din`==`cand`×7, go S7→S8.
  - S8: compare `din`==`cand`<<3. Go IDLE. Set `d_valid`=1 and `d_out`=`cand` if no fault was recorded; otherwise set `d_err`=1.
- Sticky fault bit accumulates word0 and compare faults. It is cleared on each new capture.
- `input_grant`=1 while in S3/S7/S8 (premature restart):
  - abort the current sequence with a `d_err` pulse;
  - treat `din` as the new word0 (capture, fault check, go S3).
- Every `d_err` pulse increments `err_cnt`. The count saturates at 255.
- Products are computed exactly in 11 bits. Max 255×8=2040 fits, so there is no wrap.
- Back-to-back sequences are supported:
  - grant in the cycle right after the S8 word is accepted from IDLE;
  - the previous result pulse occurs in that same cycle, independently.

## Timing
- Reset values: state IDLE, `d_out`=0, `d_valid`=0, `d_err`=0, `err_cnt`=0, `cand`=0, fault=0.
- All outputs are registered.
- Latency: `d_valid`/`d_err` are high in C4, one cycle after the d×8 word. `d_out` updates on the same edge.
- Abort `d_err` is high in the cycle after the premature grant.
- `d_valid` and `d_err` are never high together.
- Throughput: one operand per 4 cycles.
- Reset asserted mid-sequence: the sequence is discarded. No `d_valid`/`d_err` pulse. `err_cnt` clears.
- Reset takes priority over a grant in the same cycle.

## Configuration
- Macro `MULTI_SEL_DEC_CHK_EN`.
- Defined: full checking as above (word0 upper bits, compares, abort errors, `err_cnt`).
- Undefined:
  - no compares and no fault tracking;
  - `d_err` and `err_cnt` are tied to 0;
  - a premature grant silently restarts the sequence;
  - `d_valid` pulses after every completed 4-word sequence, with `d_out`=captured `din[7:0]`.

## Test plan
- Nominal: grant + `din`=143, 429, 1001, 1144 → C4 `d_valid`=1, `d_out`=143, `d_err`=0.
- Extremes, back-to-back: 255, 765, 1785, 2040 followed immediately by 0, 0, 0, 0 → `d_out`=255 then `d_out`=0, two `d_valid` pulses 4 cycles apart.
- Corrupt word: 6, 18, 41 (expect 42), 48 → C4 `d_err`=1, no `d_valid`, `err_cnt`=1. Without `MULTI_SEL_DEC_CHK_EN` → `d_valid`=1, `d_out`=6.
- Premature grant: 128, 384, then grant with 7, 21, 49, 56 → `d_err` pulse in the cycle after the second grant, `err_cnt`=1, then `d_valid` with `d_out`=7.
- Word0 fault and reset:
  - grant with `din`=0x18F followed by 143×3/7/8 → `d_err`.
  - Separately, `rst` asserted in S7 → no pulse, `err_cnt`=0, next sequence decodes normally.
- Saturation: 300 corrupt sequences → `err_cnt` stays at 255.
